// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared ALU codes and divider state encoding
package div_ctrl_pkg;

    localparam logic [4:0] ALU_DIV  = 5'b00100;
    localparam logic [4:0] ALU_DIVU = 5'b00101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] ctrl);
        return (ctrl == ALU_DIV) || (ctrl == ALU_DIVU);
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX-stage request / HI-LO result handshake bundle
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                   valid_i;
    logic [4:0]             alu_control_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   annul_i;
    logic                   ack_i;
    logic                   stall_o;
    logic                   ready_o;
    logic [2*WIDTH-1:0]     result_o;

    modport master (
        output valid_i, alu_control_i, opdata1_i, opdata2_i, annul_i, ack_i,
        input  stall_o, ready_o, result_o
    );

    modport slave (
        input  valid_i, alu_control_i, opdata1_i, opdata2_i, annul_i, ack_i,
        output stall_o, ready_o, result_o
    );
endinterface

// File: rtl/div_ctrl_step.sv
// rtl/div_ctrl_step.sv - one combinational restoring-divide iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    // One extra bit keeps the shifted remainder exact before the compare.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted  = {rem, dvd_bit};
    assign diff     = shifted - {1'b0, dvs};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU sequencer beside the EX-stage ALU
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       resetn,
    div_ctrl_if.slave  dif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_t         state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dvd, dvs, rem, quo;
    logic               q_neg, r_neg;
    logic [2*WIDTH-1:0] result;

    logic               start, signed_op, launch, div_zero;
    logic [WIDTH-1:0]   a_abs, b_abs, rem_next, quo_next, rem_fix, quo_fix;
    logic               q_bit;

    assign start     = dif.valid_i & is_div_op(dif.alu_control_i);
    assign signed_op = ~dif.alu_control_i[0];
    assign launch    = (state == IDLE) & start & ~dif.annul_i;
    assign div_zero  = (dif.opdata2_i == '0);

    // Negating 0x80000000 yields 0x80000000, which is the desired magnitude.
    assign a_abs = (signed_op & dif.opdata1_i[WIDTH-1]) ? -dif.opdata1_i : dif.opdata1_i;
    assign b_abs = (signed_op & dif.opdata2_i[WIDTH-1]) ? -dif.opdata2_i : dif.opdata2_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd[WIDTH-1]),
        .dvs      (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign quo_next = {quo[WIDTH-2:0], q_bit};
    assign rem_fix  = r_neg ? -rem_next : rem_next;
    assign quo_fix  = q_neg ? -quo_next : quo_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (launch)                        state_next = div_zero ? ZERO : BUSY;
            BUSY: if (dif.annul_i)                   state_next = IDLE;
                  else if (cnt == LAST)              state_next = DONE;
            ZERO:                                    state_next = dif.annul_i ? IDLE : DONE;
            DONE: if (dif.annul_i || dif.ack_i)      state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    always_comb begin
        dif.ready_o  = (state == DONE);
        dif.stall_o  = launch | (state == BUSY) | (state == ZERO) |
                       ((state == DONE) & ~dif.ack_i);
        dif.result_o = result;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (launch) begin
                    // A zero divisor keeps the raw dividend for the HI result.
                    dvd   <= div_zero ? dif.opdata1_i : a_abs;
                    dvs   <= b_abs;
                    q_neg <= signed_op & (dif.opdata1_i[WIDTH-1] ^ dif.opdata2_i[WIDTH-1]);
                    r_neg <= signed_op & dif.opdata1_i[WIDTH-1];
                    cnt   <= '0;
                    rem   <= '0;
                    quo   <= '0;
                end
                BUSY: if (!dif.annul_i) begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) result <= {rem_fix, quo_fix};
                end
                ZERO: if (!dif.annul_i) result <= {dvd, {WIDTH{1'b1}}};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with random and directed divides
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_ctrl_if #(.WIDTH(32)) bus ();

    div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .dif    (bus)
    );

    logic [63:0] exp_q[$];
    int          start_q[$];
    int          lat_q[$];
    logic        ready_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] ctrl, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (ctrl == ALU_DIVU) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = $signed(a);
            sb = $signed(b);
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Monitor: each fresh ready_o pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (resetn && bus.ready_o && !ready_d) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                int          s, l;
                e = exp_q.pop_front();
                s = start_q.pop_front();
                l = lat_q.pop_front();
                chk("result", bus.result_o, e);
                chk("latency", 64'(cyc - s), 64'(l));
            end
        end
        ready_d <= resetn & bus.ready_o;
    end

    task automatic expect_op(input logic [63:0] e, input logic [31:0] b);
        exp_q.push_back(e);
        start_q.push_back(cyc);
        lat_q.push_back(b == 0 ? 2 : 33);
    endtask

    task automatic wait_ready(output int bad_stall);
        int n = 0;
        bad_stall = 0;
        while (!bus.ready_o && n < 60) begin
            if (!bus.stall_o) bad_stall++;
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 64'(bus.ready_o), 64'd1);
    endtask

    task automatic run_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input int ack_wait);
        int          bad;
        logic [63:0] r0;
        @(negedge clk);
        bus.valid_i       = 1'b1;
        bus.alu_control_i = ctrl;
        bus.opdata1_i     = a;
        bus.opdata2_i     = b;
        bus.ack_i         = (ack_wait == 0);
        expect_op(e, b);
        @(negedge clk);
        bus.valid_i = 1'b0;
        wait_ready(bad);
        chk("stall_while_busy", 64'(bad), 64'd0);
        if (ack_wait == 0) begin
            chk("stall_released_on_ack", 64'(bus.stall_o), 64'd0);
        end else begin
            r0 = bus.result_o;
            repeat (ack_wait) begin
                @(negedge clk);
                chk("done_hold", {61'd0, bus.ready_o, bus.stall_o, bus.result_o == r0}, 64'd7);
            end
            bus.ack_i = 1'b1;
        end
        @(negedge clk);
        chk("idle_after_ack", {62'd0, bus.ready_o, bus.stall_o}, 64'd0);
    endtask

    initial begin
        logic [4:0]  c;
        logic [31:0] a, b;
        int          bad;

        bus.valid_i = 0; bus.alu_control_i = 0; bus.opdata1_i = 0; bus.opdata2_i = 0;
        bus.annul_i = 0; bus.ack_i = 1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.result_o[61:0], bus.ready_o, bus.stall_o}, 64'd0);
        resetn = 1'b1;

        run_op(ALU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        run_op(ALU_DIV, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_op(ALU_DIV, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}, 1);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
        run_op(ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 0);
        run_op(ALU_DIV, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 0);
        run_op(ALU_DIVU, 32'd1000, 32'd33, {32'd10, 32'd30}, 5);

        // Annul in flight: the aborted divide must never produce ready_o.
        @(negedge clk);
        bus.valid_i = 1; bus.alu_control_i = ALU_DIV; bus.opdata1_i = 1000; bus.opdata2_i = 3;
        @(negedge clk);
        bus.valid_i = 0;
        repeat (8) @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0;
        chk("annul_to_idle", {62'd0, bus.ready_o, bus.stall_o}, 64'd0);
        run_op(ALU_DIVU, 32'd9, 32'd4, {32'd1, 32'd2}, 0);

        // Start held through DONE: operands change while DONE, only the IDLE sample launches.
        @(negedge clk);
        bus.valid_i = 1; bus.alu_control_i = ALU_DIVU; bus.opdata1_i = 50; bus.opdata2_i = 7;
        bus.ack_i = 0;
        expect_op({32'd1, 32'd7}, 32'd7);
        @(negedge clk);
        wait_ready(bad);
        @(negedge clk);
        chk("held_start_done", {62'd0, bus.ready_o, bus.stall_o}, 64'd3);
        bus.ack_i = 1; bus.opdata1_i = 60; bus.opdata2_i = 9;
        @(negedge clk);
        chk("held_start_relaunch", {62'd0, bus.ready_o, bus.stall_o}, 64'd1);
        expect_op({32'd6, 32'd6}, 32'd9);
        @(negedge clk);
        bus.valid_i = 0;
        wait_ready(bad);
        @(negedge clk);

        // Asynchronous reset mid-BUSY, away from any clock edge.
        @(negedge clk);
        bus.valid_i = 1; bus.alu_control_i = ALU_DIV; bus.opdata1_i = 12345; bus.opdata2_i = 11;
        @(negedge clk);
        bus.valid_i = 0;
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk("async_reset", {bus.result_o[61:0], bus.ready_o, bus.stall_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(ALU_DIV, -32'sd100, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0);

        for (int i = 0; i < 24; i++) begin
            c = ($urandom_range(0, 1) == 0) ? ALU_DIV : ALU_DIVU;
            a = $urandom();
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = -32'($urandom_range(1, 15));
                default: b = $urandom();
            endcase
            if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(c, a, b, model(c, a, b), $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
